modexp_ladder: RTL and testbench

MODEXP_LADDER -- requirements
Module: modexp_ladder

---
 rtl/modexp_pkg.sv | 19 +
 rtl/mont_mult.sv | 79 +++++++
 rtl/modexp_ladder.sv | 228 ++++++++++++++++++++++
 tb/tb_modexp_ladder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared definitions for the Montgomery-ladder modular exponentiator.
// Contents: default operand/length widths and the controller state encoding.
package modexp_pkg;

    localparam int unsigned DEF_WIDTH = 1024;
    localparam int unsigned DEF_LEN_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TOMONT    = 3'd1,
        ST_SCAN      = 3'd2,
        ST_STEP_GO   = 3'd3,
        ST_STEP_WAIT = 3'd4,
        ST_FROM_GO   = 3'd5,
        ST_FROM_WAIT = 3'd6,
        ST_DONE      = 3'd7
    } state_e;

endpackage

// File: rtl/mont_mult.sv
// Bit-serial Montgomery multiplier: result = a * b * 2^-WIDTH mod m.
// One multiplier bit per cycle; done pulses one cycle after the last bit.
// Ports:
//   clk, resetn     clock, synchronous active-low reset
//   start           accepted only while idle; a, b, m captured then
//   a, b, m         operands (a, b < m, m odd)
//   result          product, held until the next accepted start completes
//   done            one-cycle pulse when result is updated
module mont_mult #(
    parameter int unsigned WIDTH = 1024
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q, b_q, m_q, res_q;
    logic [WIDTH+1:0] s_q;
    logic [WIDTH+1:0] s_add, s_red, s_d;
    logic [WIDTH-1:0] s_fin;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q, done_q;

    // The partial sum stays below 2m throughout, so WIDTH+2 bits suffice and
    // a single conditional subtraction finishes the reduction.
    always_comb begin
        s_add = s_q + (a_q[0] ? {2'b00, b_q} : '0);
        s_red = s_add + (s_add[0] ? {2'b00, m_q} : '0);
        s_d   = s_red >> 1;
        if (s_d >= {2'b00, m_q}) begin
            s_fin = WIDTH'(s_d - {2'b00, m_q});
        end else begin
            s_fin = s_d[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            s_q    <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (run_q) begin
                s_q   <= s_d;
                a_q   <= a_q >> 1;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    run_q  <= 1'b0;
                    res_q  <= s_fin;
                    done_q <= 1'b1;
                end
            end else if (start) begin
                a_q   <= a;
                b_q   <= b;
                m_q   <= m;
                s_q   <= '0;
                cnt_q <= CNT_W'(WIDTH);
                run_q <= 1'b1;
            end
        end
    end

    assign result = res_q;
    assign done   = done_q;

endmodule

// File: rtl/modexp_ladder.sv
// Modular exponentiation x^e mod m using a Montgomery ladder over two
// Montgomery multipliers. Multiplier 1 also performs the conversions into and
// out of the Montgomery domain.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   start                  request, sampled only in IDLE
//   in_x, in_m, in_e       base, odd modulus, exponent
//   in_r, in_r2            2^WIDTH mod m, 2^(2*WIDTH) mod m
//   lene                   number of exponent bits used (clamped to WIDTH)
//   result                 x^e mod m, valid from done until the next start
//   done                   one-cycle completion pulse
//   busy                   high from the cycle after start through done
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for start; operands captured on start
// TOMONT     | R1 := mont(x, r2); R0 already holds r (Montgomery one)
// SCAN       | CONST_TIME=0: strip leading zero exponent bits, one per cycle
// STEP_GO    | launch both ladder multiplications, clear done latches
// STEP_WAIT  | wait for both done latches, then update R0/R1 and shift
// FROM_GO    | launch mont(R0, 1)
// FROM_WAIT  | wait for conversion result
// DONE       | done pulse, back to IDLE
module modexp_ladder
    import modexp_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned LEN_W      = DEF_LEN_W,
    parameter bit          CONST_TIME = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_m,
    input  logic [WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_r2,
    input  logic [LEN_W-1:0] lene,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    localparam int unsigned    CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, m_q, m_d, r2_q, r2_d, e_q, e_d;
    logic [WIDTH-1:0] r0_q, r0_d, r1_q, r1_d, res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             d0_q, d0_d, d1_q, d1_d;
    logic             tgo_q, tgo_d;

    logic [LEN_W+31:0] lene_ext;
    logic [CNT_W-1:0]  lene_cl, shamt;
    logic              ebit;

    logic             m0_start, m1_start, m0_done, m1_done;
    logic [WIDTH-1:0] m1_a, m1_b, m0_res, m1_res;

    assign lene_ext = {32'd0, lene};
    assign lene_cl  = (lene_ext > (LEN_W+32)'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(lene);
    // Left-align so exponent bit lene-1 lands on the MSB; lene=0 shifts all out.
    assign shamt    = CNT_W'(WIDTH) - lene_cl;
    assign ebit     = e_q[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            m_q     <= '0;
            r2_q    <= '0;
            e_q     <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            d0_q    <= 1'b0;
            d1_q    <= 1'b0;
            tgo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            m_q     <= m_d;
            r2_q    <= r2_d;
            e_q     <= e_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            tgo_q   <= tgo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        m_d     = m_q;
        r2_d    = r2_q;
        e_d     = e_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        tgo_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = in_x;
                    m_d     = in_m;
                    r2_d    = in_r2;
                    r0_d    = in_r;
                    e_d     = in_e << shamt;
                    cnt_d   = lene_cl;
                    tgo_d   = 1'b1;
                    state_d = ST_TOMONT;
                end
            end
            ST_TOMONT: begin
                if (m1_done) begin
                    r1_d    = m1_res;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cnt_q == '0) begin
                    state_d = ST_FROM_GO;
                end else if (!CONST_TIME && !ebit) begin
                    e_d   = e_q << 1;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_STEP_GO;
                end
            end
            ST_STEP_GO: begin
                d0_d    = 1'b0;
                d1_d    = 1'b0;
                state_d = ST_STEP_WAIT;
            end
            ST_STEP_WAIT: begin
                if (m0_done) d0_d = 1'b1;
                if (m1_done) d1_d = 1'b1;
                if (d0_q && d1_q) begin
                    // Multiplier 0 always yields R0*R1; multiplier 1 the square.
                    if (ebit) begin
                        r0_d = m0_res;
                        r1_d = m1_res;
                    end else begin
                        r1_d = m0_res;
                        r0_d = m1_res;
                    end
                    e_d     = e_q << 1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(1)) ? ST_FROM_GO : ST_STEP_GO;
                end
            end
            ST_FROM_GO: begin
                state_d = ST_FROM_WAIT;
            end
            ST_FROM_WAIT: begin
                if (m1_done) begin
                    res_d   = m1_res;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand selects come only from registered state and the exponent MSB.
    always_comb begin
        m1_a = x_q;
        m1_b = r2_q;
        case (state_q)
            ST_STEP_GO: begin
                m1_a = ebit ? r1_q : r0_q;
                m1_b = ebit ? r1_q : r0_q;
            end
            ST_FROM_GO: begin
                m1_a = r0_q;
                m1_b = ONE;
            end
            default: begin
            end
        endcase
    end

    assign m0_start = (state_q == ST_STEP_GO);
    assign m1_start = (state_q == ST_STEP_GO) || (state_q == ST_FROM_GO) || tgo_q;

    mont_mult #(.WIDTH(WIDTH)) u_mult0 (
        .clk    (clk),
        .resetn (resetn),
        .start  (m0_start),
        .a      (r0_q),
        .b      (r1_q),
        .m      (m_q),
        .result (m0_res),
        .done   (m0_done)
    );

    mont_mult #(.WIDTH(WIDTH)) u_mult1 (
        .clk    (clk),
        .resetn (resetn),
        .start  (m1_start),
        .a      (m1_a),
        .b      (m1_b),
        .m      (m_q),
        .result (m1_res),
        .done   (m1_done)
    );

    assign result = res_q;
    assign done   = (state_q == ST_DONE);
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_modexp_ladder.sv
// Bench for modexp_ladder: a constant-time and a leading-zero-skipping
// instance run side by side on the same operands.
module tb_modexp_ladder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [1:0]   st = 2'b00;
    logic [W-1:0] in_x = '0, in_m = '0, in_e = '0, in_r = '0, in_r2 = '0;
    logic [31:0]  lene = '0;
    logic [W-1:0] res0, res1;
    logic [1:0]   dn, bz;

    int total = 0;
    int bad   = 0;

    // Run bookkeeping: req is written by the stimulus, seen/valid/cyc by the checker.
    int           req[2] = '{0, 0};
    int           seen[2] = '{0, 0};
    bit           abort_run = 1'b0;
    bit           valid[2] = '{1'b0, 1'b0};
    logic [W-1:0] exp_r[2];
    int           cyc[2] = '{0, 0};
    int           last_cyc[2] = '{0, 0};

    always #5 clk = ~clk;

    modexp_ladder #(.WIDTH(W), .LEN_W(32), .CONST_TIME(1'b1)) dut_ct (
        .clk(clk), .resetn(resetn), .start(st[0]),
        .in_x(in_x), .in_m(in_m), .in_e(in_e), .in_r(in_r), .in_r2(in_r2),
        .lene(lene), .result(res0), .done(dn[0]), .busy(bz[0])
    );

    modexp_ladder #(.WIDTH(W), .LEN_W(32), .CONST_TIME(1'b0)) dut_nc (
        .clk(clk), .resetn(resetn), .start(st[1]),
        .in_x(in_x), .in_m(in_m), .in_e(in_e), .in_r(in_r), .in_r2(in_r2),
        .lene(lene), .result(res1), .done(dn[1]), .busy(bz[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    // Right-to-left square-and-multiply over the low min(len, W) bits.
    function automatic longint model_exp(longint x, longint e, int len, longint m);
        int     n;
        longint acc, b;
        n   = (len > W) ? W : len;
        acc = 1 % m;
        b   = x % m;
        for (int i = 0; i < n; i++) begin
            if (e[i]) acc = (acc * b) % m;
            b = (b * b) % m;
        end
        return acc;
    endfunction

    function automatic longint rmod(longint m);
        return (longint'(1) << W) % m;
    endfunction

    // Per-cycle checker.
    initial begin
        @(posedge resetn);
        forever begin
            @(negedge clk);
            if (!resetn) begin
                for (int k = 0; k < 2; k++) begin
                    seen[k]  = req[k];
                    valid[k] = 1'b0;
                    cyc[k]   = 0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    logic [W-1:0] r;
                    bit           pend;
                    string        nm;
                    r    = (k == 0) ? res0 : res1;
                    nm   = (k == 0) ? "ct" : "nc";
                    pend = (req[k] != seen[k]);
                    if (pend && bz[k]) cyc[k]++;
                    if (!pend || abort_run) begin
                        chk({"no_done_", nm}, dn[k], 0);
                    end
                    if (!pend) begin
                        chk({"busy_idle_", nm}, bz[k], 0);
                        if (valid[k]) chk({"result_hold_", nm}, r, exp_r[k]);
                    end else if (!abort_run && dn[k]) begin
                        chk({"result_", nm}, r, exp_r[k]);
                        chk({"busy_at_done_", nm}, bz[k], 1);
                        last_cyc[k] = cyc[k];
                        cyc[k]      = 0;
                        seen[k]     = req[k];
                        valid[k]    = 1'b1;
                    end
                end
            end
        end
    end

    task automatic set_ops(input logic [W-1:0] x, m, e, input int len);
        longint r, r2;
        r     = rmod(longint'(m));
        r2    = (r * r) % longint'(m);
        in_x  = x;
        in_m  = m;
        in_e  = e;
        in_r  = W'(r);
        in_r2 = W'(r2);
        lene  = 32'(len);
    endtask

    task automatic scramble();
        in_x  = W'($urandom);
        in_m  = W'($urandom);
        in_e  = W'($urandom);
        in_r  = W'($urandom);
        in_r2 = W'($urandom);
        lene  = $urandom;
    endtask

    task automatic run(input logic [W-1:0] x, m, e, input int len, input bit hammer);
        longint     ex;
        logic [1:0] got, rel;
        ex = model_exp(longint'(x), longint'(e), len, longint'(m));
        @(negedge clk);
        set_ops(x, m, e, len);
        exp_r[0] = W'(ex);
        exp_r[1] = W'(ex);
        req[0]++;
        req[1]++;
        st = 2'b11;
        @(negedge clk);
        if (!hammer) st = 2'b00;
        scramble();
        got = 2'b00;
        rel = 2'b00;
        for (int c = 0; c < 3000 && rel != 2'b11; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (got[k]) begin
                    st[k]  = 1'b0;
                    rel[k] = 1'b1;
                end
                if (dn[k]) got[k] = 1'b1;
            end
        end
        chk("run_completes", rel, 2'b11);
        st = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_done_ct"}, dn[0], 0);
        chk({tag, "_done_nc"}, dn[1], 0);
        chk({tag, "_busy_ct"}, bz[0], 0);
        chk({tag, "_busy_nc"}, bz[1], 0);
        chk({tag, "_result_ct"}, res0, 0);
        chk({tag, "_result_nc"}, res1, 0);
    endtask

    task automatic abort_run_mid();
        @(negedge clk);
        set_ops(16'd2, 16'd13, 16'h000A, 4);
        abort_run = 1'b1;
        req[0]++;
        req[1]++;
        st = 2'b11;
        @(negedge clk);
        st = 2'b00;
        scramble();
        repeat (26) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_reset_state("abort_reset");
        @(negedge clk);
        resetn    = 1'b1;
        abort_run = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c_a4, c_0, step;

        // Hand-computed anchors for the model (m=13, W=16).
        chk("model_r", rmod(13), 3);
        chk("model_r2", (rmod(13) * rmod(13)) % 13, 9);
        chk("model_2_0xA", model_exp(2, 'hA, 4, 13), 10);
        chk("model_2_0xB", model_exp(2, 'hB, 4, 13), 7);
        chk("model_2_0x1", model_exp(2, 'h1, 16, 13), 2);
        chk("model_len0", model_exp(9, 'hF, 0, 13), 1);

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        run(16'd2, 16'd13, 16'h000A, 4, 1'b0);
        c_a4 = last_cyc[0];
        run(16'd2, 16'd13, 16'h000B, 4, 1'b0);
        chk("ct_cycles_e0xB", last_cyc[0], c_a4);
        run(16'd2, 16'd13, 16'h0000, 4, 1'b0);
        chk("ct_cycles_e0x0", last_cyc[0], c_a4);

        run(16'd7, 16'd13, 16'h0005, 0, 1'b0);
        c_0 = last_cyc[0];
        chk("nc_cycles_len0", last_cyc[1], c_0);
        chk("step_cost_uniform", (c_a4 - c_0) % 4, 0);
        step = (c_a4 - c_0) / 4;

        run(16'd2, 16'd13, 16'h0001, 16, 1'b0);
        chk("nc_one_step", last_cyc[1], c_0 + 15 + step);
        chk("ct_sixteen_steps", last_cyc[0], c_0 + 16 * step);

        run(16'd2, 16'd13, 16'h00FF, 4, 1'b0);
        run(16'd4, 16'd13, 16'h0005, 40, 1'b0);
        chk("ct_clamped_len", last_cyc[0], c_0 + 16 * step);
        run(16'd12, 16'd13, 16'hFFFF, 16, 1'b0);
        run(16'd1234, 16'd65521, 16'h8001, 16, 1'b0);
        run(16'd3, 16'd65521, 16'hFFFF, 16, 1'b0);

        abort_run_mid();
        run(16'd2, 16'd13, 16'h000A, 4, 1'b0);
        chk("post_abort_cycles", last_cyc[0], c_a4);

        run(16'd2, 16'd13, 16'h000A, 4, 1'b1);
        chk("hammer_cycles", last_cyc[0], c_a4);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
